// File: rtl/fetch_sequencer_pkg.sv
// Shared instruction-set definitions for the fetch path: opcode encodings,
// instruction field positions, fetch FSM states and the prefetch buffer entry.
package fetch_sequencer_pkg;

  localparam int INSTR_W     = 28;
  localparam int PC_W        = 16;
  localparam int OPCODE_MSB  = 27;
  localparam int OPCODE_LSB  = 24;
  localparam int JMP_TGT_MSB = 23;
  localparam int JMP_TGT_LSB = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_JMP = 4'h1,
    OP_STO = 4'h2,
    OP_ADD = 4'h3,
    OP_LED = 4'h4
  } opcode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] word);
    return opcode_e'(word[OPCODE_MSB:OPCODE_LSB]);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Prefetch FIFO of {instr, pc} entries (DEPTH 1 or 2), head always at slot 0.
// Push into a full buffer is accepted only together with a pop; flush wins over both.
module fetch_buffer
  import fetch_sequencer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [1:0]   count_q, count_d;
  logic [1:0]   base;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'(DEPTH));
  assign head_o  = mem_q[0];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    base    = count_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      if (pop_i && !empty_o) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mem_d[i] = mem_q[i + 1];
        end
        base = count_q - 2'd1;
      end
      // base is the first free slot after an optional pop this cycle
      if (push_i && (base < 2'(DEPTH))) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (2'(i) == base) begin
            mem_d[i] = din_i;
          end
        end
        count_d = base + 2'd1;
      end else begin
        count_d = base;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= 2'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC, RUN/HALT FSM, redirect and a prefetch buffer.
// Optional FETCH_JMP_FOLD_EN folds JMP words into the PC instead of delivering them.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'd0,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oRomAddress,
  input  logic [27:0] iRomInstruction,
  output logic [27:0] oInstruction,
  output logic [15:0] oInstrPC,
  output logic        oValid,
  input  logic        iReady,
  input  logic        iRedirect,
  input  logic [15:0] iRedirectAddr,
  input  logic        iHalt
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic         buf_full, buf_empty;
  logic         pop, fetch, push, is_jmp;
  fetch_entry_t head, push_entry;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (iHalt)  state_d = ST_HALT;
      ST_HALT: if (!iHalt) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pop    = !buf_empty && iReady && !iRedirect;
    fetch  = (state_q == ST_RUN) && (!buf_full || pop) && !iRedirect;
    is_jmp = 1'b0;
`ifdef FETCH_JMP_FOLD_EN
    is_jmp = (get_opcode(iRomInstruction) == OP_JMP);
`endif
    push = fetch && !is_jmp;
    pc_d = pc_q;
    if (iRedirect) begin
      pc_d = iRedirectAddr;
    end else if (fetch) begin
      // a folded JMP spends its fetch slot loading the target instead of pushing
      pc_d = is_jmp ? {8'd0, iRomInstruction[JMP_TGT_MSB:JMP_TGT_LSB]} : pc_q + 16'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign push_entry = '{instr: iRomInstruction, pc: pc_q};

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .push_i (push),
    .pop_i  (pop),
    .flush_i(iRedirect),
    .din_i  (push_entry),
    .head_o (head),
    .full_o (buf_full),
    .empty_o(buf_empty)
  );

  assign oRomAddress  = pc_q;
  assign oValid       = !buf_empty;
  assign oInstruction = buf_empty ? 28'd0 : head.instr;
  assign oInstrPC     = buf_empty ? 16'd0 : head.pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: cycle vector table plus scoreboarded multi-cycle sequences.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oRomAddress;
  logic [27:0] iRomInstruction;
  logic [27:0] oInstruction;
  logic [15:0] oInstrPC;
  logic        oValid;
  logic        iReady = 1'b0;
  logic        iRedirect = 1'b0;
  logic [15:0] iRedirectAddr = 16'd0;
  logic        iHalt = 1'b0;

  int checks = 0;
  int errors = 0;
  bit sb_en  = 1'b0;
  logic [15:0] sb_q [$];

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .Clock          (clk),
    .Reset          (Reset),
    .oRomAddress    (oRomAddress),
    .iRomInstruction(iRomInstruction),
    .oInstruction   (oInstruction),
    .oInstrPC       (oInstrPC),
    .oValid         (oValid),
    .iReady         (iReady),
    .iRedirect      (iRedirect),
    .iRedirectAddr  (iRedirectAddr),
    .iHalt          (iHalt)
  );

  function automatic logic [27:0] rom_word(input logic [15:0] a);
    if (a == 16'd7) return {OP_JMP, 8'd3, 16'd7};
    return {OP_ADD, a[7:0], a};
  endfunction

  assign iRomInstruction = rom_word(oRomAddress);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && sb_q.size() != 0; i++) step();
    iReady = 1'b0;
    chk(name, sb_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (sb_en && oValid && iReady && !iRedirect && !Reset) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual_pc=%h required=none", oInstrPC);
      end else begin
        logic [15:0] exp_pc;
        exp_pc = sb_q.pop_front();
        chk("sb_pc", oInstrPC, exp_pc);
        chk("sb_instr", oInstruction, rom_word(exp_pc));
      end
    end
  end

  typedef struct {
    logic        rst, rdy, rdr;
    logic [15:0] raddr;
    logic        ev;
    logic [15:0] ep, ea;
    logic        hd;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  function automatic vec_t v(input logic rst, input logic rdy, input logic rdr, input logic [15:0] raddr,
                             input logic ev, input logic [15:0] ep, input logic [15:0] ea, input logic hd);
    vec_t r;
    r.rst = rst; r.rdy = rdy; r.rdr = rdr; r.raddr = raddr;
    r.ev = ev; r.ep = ep; r.ea = ea; r.hd = hd;
    return r;
  endfunction

  vec_t tbl [25];

  initial begin
    // reset, streaming, fill, reset-while-full, stall, redirect, PC wrap
    tbl[0]  = v(T, T, F, 16'h0000, F, 16'h0000, 16'h0000, T);
    tbl[1]  = v(F, T, F, 16'h0000, F, 16'h0000, 16'h0000, T);
    tbl[2]  = v(F, T, F, 16'h0000, T, 16'h0000, 16'h0001, T);
    tbl[3]  = v(F, T, F, 16'h0000, T, 16'h0001, 16'h0002, T);
    tbl[4]  = v(F, F, F, 16'h0000, T, 16'h0002, 16'h0003, T);
    tbl[5]  = v(F, F, F, 16'h0000, T, 16'h0002, 16'h0004, T);
    tbl[6]  = v(F, F, F, 16'h0000, T, 16'h0002, 16'h0004, T);
    tbl[7]  = v(T, F, F, 16'h0000, T, 16'h0002, 16'h0004, T);
    tbl[8]  = v(F, F, F, 16'h0000, F, 16'h0000, 16'h0000, T);
    tbl[9]  = v(F, F, F, 16'h0000, T, 16'h0000, 16'h0001, T);
    for (int i = 10; i <= 14; i++) tbl[i] = v(F, F, F, 16'h0000, T, 16'h0000, 16'h0002, T);
    tbl[15] = v(F, T, F, 16'h0000, T, 16'h0000, 16'h0002, T);
    tbl[16] = v(F, T, F, 16'h0000, T, 16'h0001, 16'h0003, T);
    tbl[17] = v(F, T, F, 16'h0000, T, 16'h0002, 16'h0004, T);
    tbl[18] = v(F, T, T, 16'h0004, T, 16'h0003, 16'h0005, T);
    tbl[19] = v(F, T, F, 16'h0000, F, 16'h0000, 16'h0004, F);
    tbl[20] = v(F, T, F, 16'h0000, T, 16'h0004, 16'h0005, T);
    tbl[21] = v(F, T, T, 16'hFFFF, T, 16'h0005, 16'h0006, T);
    tbl[22] = v(F, T, F, 16'h0000, F, 16'h0000, 16'hFFFF, F);
    tbl[23] = v(F, T, F, 16'h0000, T, 16'hFFFF, 16'h0000, T);
    tbl[24] = v(F, T, F, 16'h0000, T, 16'h0000, 16'h0001, T);

    Reset = 1'b1;
    step();
    step();
    for (int i = 0; i < 25; i++) begin
      Reset         = tbl[i].rst;
      iReady        = tbl[i].rdy;
      iRedirect     = tbl[i].rdr;
      iRedirectAddr = tbl[i].raddr;
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), oValid, tbl[i].ev);
      chk($sformatf("row%0d_romaddr", i), oRomAddress, tbl[i].ea);
      if (tbl[i].hd) begin
        chk($sformatf("row%0d_pc", i), oInstrPC, tbl[i].ep);
        chk($sformatf("row%0d_instr", i), oInstruction, tbl[i].ev ? rom_word(tbl[i].ep) : 28'd0);
      end
      step();
    end
    iRedirect = 1'b0;
    iReady    = 1'b0;

    // halt with a full buffer: drain, freeze, redirect while halted, resume
    sb_en = 1'b1;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    step();
    step();
    step();
    iHalt = 1'b1;
    step();
    @(negedge clk);
    chk("halt_full_addr", oRomAddress, 16'd2);
    sb_q.push_back(16'd0);
    sb_q.push_back(16'd1);
    @(posedge clk);
    #1;
    iReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("halt_addr_frozen", oRomAddress, 16'd2);
      step();
    end
    @(negedge clk);
    chk("halt_drained_valid", oValid, 1'b0);
    chk("halt_drained_queue", sb_q.size(), 0);
    step();
    iRedirect     = 1'b1;
    iRedirectAddr = 16'd10;
    step();
    iRedirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_redir_addr", oRomAddress, 16'd10);
      chk("halt_redir_valid", oValid, 1'b0);
      step();
    end
    for (int p = 10; p <= 13; p++) sb_q.push_back(16'(p));
    iHalt = 1'b0;
    drain("halt_resume_drain", 20);

    // JMP at word 7 targeting word 3
    Reset = 1'b1;
    step();
    step();
`ifdef FETCH_JMP_FOLD_EN
    for (int p = 0; p <= 6; p++) sb_q.push_back(16'(p));
    for (int p = 3; p <= 6; p++) sb_q.push_back(16'(p));
    sb_q.push_back(16'd3);
`else
    for (int p = 0; p <= 9; p++) sb_q.push_back(16'(p));
`endif
    Reset  = 1'b0;
    iReady = 1'b1;
    drain("jmp_drain", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'd0: program counter value loaded on reset.
REQ-002 Parameter BUF_DEPTH, default 2: prefetch buffer entries; legal values 1 or 2 only.
REQ-003 Clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 oRomAddress  output  16  program counter, driven combinationally to the instruction ROM address.
REQ-006 iRomInstruction  input  28  ROM word for oRomAddress, available in the same cycle; opcode is [27:23+1], i.e. [27:24].
REQ-007 oInstruction  output  28  instruction at the buffer head.
REQ-008 oInstrPC  output  16  ROM address of the oInstruction word.
REQ-009 oValid  output  1  buffer head holds a valid instruction.
REQ-010 iReady  input  1  consumer accepts the head; a pop occurs when oValid and iReady are both high.
REQ-011 iRedirect  input  1  consumer-requested PC redirect, single-cycle pulse.
REQ-012 iRedirectAddr  input  16  redirect target address.
REQ-013 iHalt  input  1  level request to stop fetching.

Function
REQ-014 FSM states: RUN and HALT; iHalt=1 in RUN goes to HALT; iHalt=0 in HALT returns to RUN.
REQ-015 In RUN, fetch when the buffer is not full or a pop occurs that cycle: push {iRomInstruction, PC}; PC <= PC+1.
REQ-016 PC increment wraps 16'hFFFF -> 16'h0000 with no flag or stall.
REQ-017 HALT: no push and no PC change; buffer keeps draining through the handshake; no flush.
REQ-018 Redirect priority: iRedirect overrides push, pop and halt; flush buffer; PC <= iRedirectAddr; oValid=0 next cycle.
REQ-019 An iRedirect in HALT loads PC and flushes the buffer; FSM stays HALT while iHalt=1.
REQ-020 Redirect latency: iRedirect at cycle N -> oRomAddress=target at N+1 -> oValid=1 with oInstrPC=target at N+2, if in RUN.
REQ-021 Reset-release latency: first cycle out of reset fetches RESET_PC; oValid=1 on the next cycle.
REQ-022 Full buffer with a simultaneous pop: push and pop in the same cycle; occupancy unchanged; no bubble.
REQ-023 Pop from an empty buffer is impossible: oValid=0 masks iReady.
REQ-024 oInstruction and oInstrPC are held stable while oValid=1 and iReady=0.
REQ-025 Buffer order is strict FIFO; sustained throughput with iReady held high is 1 instruction/cycle.

Reset
REQ-026 Reset sets PC=RESET_PC, empties the buffer, sets FSM=RUN and oValid=0; oInstruction=28'd0 and oInstrPC=16'd0.
REQ-027 Reset has priority over iRedirect, iHalt and the handshake; reset mid-stream discards all buffered entries.

Configuration
REQ-028 Macro FETCH_JMP_FOLD_EN defined: a fetched word with opcode == JMP is not pushed; PC <= {8'd0, word[23:16]}.
REQ-029 A folded JMP costs one fetch cycle.
REQ-030 If the buffer is full, the JMP is folded only on a fetch-eligible cycle.
REQ-031 Macro FETCH_JMP_FOLD_EN undefined: JMP words are pushed like any other instruction and PC increments normally.

Structure
REQ-032 Opcode encodings (JMP, NOP, STO, ADD, LED) stay in the shared definitions package.
REQ-033 The opcode field position constants are added to the shared definitions package.
REQ-034 Sub-module fetch_buffer: BUF_DEPTH-entry FIFO of 44-bit entries {instr, pc} with push, pop, flush, full and empty.

Verification
REQ-035 ROM holds words 0..7; reset released, iReady=1 -> oInstrPC = 0,1,2,... on consecutive cycles from cycle 1; no gaps.
REQ-036 iReady=0 for 5 cycles after 2 fetches -> oRomAddress frozen at 2; head stays PC 0.
REQ-037 Continuing REQ-036: iReady then 1 -> PCs 0,1,2 delivered with no loss or duplication.
REQ-038 iRedirect with iRedirectAddr=16'd4 at cycle 10 -> oValid=0 at 11; oValid=1 with oInstrPC=4 at 12.
REQ-039 PC preloaded to 16'hFFFF via redirect -> next fetch address 16'h0000.
REQ-040 iHalt=1 with 2 entries buffered, iReady=1 -> both drain; oValid=0; oRomAddress constant; no new fetch until iHalt=0.
REQ-041 With FETCH_JMP_FOLD_EN, ROM word 7 = JMP to 3 -> delivered PCs ...,6,3,4,5,6,3; PC 7 is never output.
REQ-042 Without FETCH_JMP_FOLD_EN, the same ROM -> PC 7 is output with the JMP opcode, followed by PC 8.
REQ-043 Reset asserted while the buffer is full -> next cycle oValid=0 and oRomAddress=RESET_PC.
